// File: rtl/pixel_window_feeder_if.sv
// rtl/pixel_window_feeder_if.sv - pixel input stream and 2x2 window output stream bundle
//
// Purpose: groups both handshaked streams of the window feeder.
// Ports (signals):
//   pix_in/pix_valid/pix_ready           raster-order pixel stream into the feeder
//   win_pixels/win_valid/win_ready/win_last  2x2 window stream out of the feeder
// Modports: master = stream source/sink side (bench or upstream/downstream),
//           slave  = the feeder itself.
interface pixel_window_feeder_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0]      pix_in;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [3:0][PIX_W-1:0] win_pixels;
    logic                  win_valid;
    logic                  win_ready;
    logic                  win_last;

    modport master (
        output pix_in, pix_valid, win_ready,
        input  pix_ready, win_pixels, win_valid, win_last
    );

    modport slave (
        input  pix_in, pix_valid, win_ready,
        output pix_ready, win_pixels, win_valid, win_last
    );
endinterface

// File: rtl/pixel_window_feeder.sv
// rtl/pixel_window_feeder.sv - raster pixel stream to overlapping 2x2 window stream
//
// Purpose: buffers one image row and emits every stride-1 2x2 window of an
// IMG_W x IMG_H frame as a packed 4-pixel word.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   start  one-cycle pulse arming capture of one frame (ignored unless idle)
//   bus    pixel in / window out streams (slave modport)
//   busy   high while capturing or draining a frame
//   done   one-cycle pulse after the final window is accepted
module pixel_window_feeder #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int PIX_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    pixel_window_feeder_if.slave        bus,
    output logic                        busy,
    output logic                        done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CW-1:0]         col_q, col_d;
    logic [PIX_W-1:0]      prev_cur_q, prev_cur_d;   // pixel (r, c-1)
    logic [PIX_W-1:0]      prev_up_q, prev_up_d;     // pixel (r-1, c-1)
    logic [3:0][PIX_W-1:0] win_pix_q, win_pix_d;
    logic                  win_valid_q, win_valid_d;
    logic                  win_last_q, win_last_d;
    logic                  pix_ready;
    logic                  accept;

    logic [PIX_W-1:0]      line_q [IMG_W];
    logic [PIX_W-1:0]      up_pix;                   // pixel (r-1, c), read before overwrite

    assign up_pix = line_q[col_q];

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        prev_cur_d  = prev_cur_q;
        prev_up_d   = prev_up_q;
        win_pix_d   = win_pix_q;
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;
        pix_ready   = 1'b0;
        accept      = 1'b0;

        // Window taken downstream; a load below in the same cycle overrides this.
        if (win_valid_q && bus.win_ready) begin
            win_valid_d = 1'b0;
            win_last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            RUN: begin
                // Single output register: accept only if it is empty or emptying now.
                pix_ready = !win_valid_q || bus.win_ready;
                accept    = pix_ready && bus.pix_valid;
                if (accept) begin
                    prev_cur_d = bus.pix_in;
                    prev_up_d  = up_pix;
                    // Column 0 never emits, so stale prev_* from the prior row is never used.
                    if (row_q != '0 && col_q != '0) begin
                        win_pix_d   = {bus.pix_in, prev_cur_q, up_pix, prev_up_q};
                        win_valid_d = 1'b1;
                        win_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
                    end
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (win_valid_q && bus.win_ready && win_last_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            prev_cur_q  <= '0;
            prev_up_q   <= '0;
            win_pix_q   <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            prev_cur_q  <= prev_cur_d;
            prev_up_q   <= prev_up_d;
            win_pix_q   <= win_pix_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
        end
    end

    // Line buffer contents are don't-care after reset; row 0 never emits.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_q[col_q] <= bus.pix_in;
        end
    end

    assign bus.pix_ready  = pix_ready;
    assign bus.win_pixels = win_pix_q;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_last   = win_last_q;
    assign busy           = (state_q == RUN) || (state_q == DRAIN);
    assign done           = (state_q == DONE);
endmodule
